// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory load/store unit.
//   - RISC-V funct3 encodings for loads and stores
//   - FSM state enum
//   - lane_info(): byte-enable mask (two 8-byte beats) and misalignment flag
package dmem_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB       = 3'b000;
   localparam logic [2:0] F3_LH       = 3'b001;
   localparam logic [2:0] F3_LW       = 3'b010;
   localparam logic [2:0] F3_LD       = 3'b011;
   localparam logic [2:0] F3_LBU      = 3'b100;
   localparam logic [2:0] F3_LHU      = 3'b101;
   localparam logic [2:0] F3_LWU      = 3'b110;
   localparam logic [2:0] F3_BAD_LOAD = 3'b111;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;
   localparam logic [2:0] F3_SD = 3'b011;

   typedef enum logic {
      IDLE  = 1'b0,
      BEAT2 = 1'b1
   } state_t;

   // be[7:0] addresses the first word, be[15:8] the spill into the next word.
   typedef struct packed {
      logic [15:0] be;
      logic        misaligned;
   } lane_t;

   function automatic lane_t lane_info(input logic [2:0] funct3, input logic [2:0] offset);
      lane_t       li;
      logic [15:0] mask;
      case (funct3[1:0])
         2'b00:   mask = 16'h0001;
         2'b01:   mask = 16'h0003;
         2'b10:   mask = 16'h000F;
         default: mask = 16'h00FF;
      endcase
      li.be         = mask << offset;
      li.misaligned = |li.be[15:8];
      return li;
   endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response bus between the MEM stage and the data memory.
//   req_valid/req_ready handshake with req_we, req_funct3, req_addr, req_wdata;
//   rsp_valid one-cycle pulse with rsp_rdata and rsp_err (no backpressure).
//   master = requester (core), slave = memory.
interface data_mem_lsu_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: single-port DEPTH_WORDS x 64 RAM with per-byte write enables and
// registered read data. Contents start at zero and are never cleared by reset.
//   clk   in   clock
//   en    in   access this edge (read always, write bytes selected by we)
//   we    in   per-byte write enables
//   addr  in   word index
//   wdata in   write data (byte lanes already positioned)
//   rdata out  word read at the last enabled edge (old contents on a write edge)
module dmem_bank #(
   parameter int DEPTH_WORDS = 512,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [7:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem_reg [DEPTH_WORDS] = '{default: '0};
   logic [63:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (en) begin
         rdata_reg <= mem_reg[addr];
         for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
               mem_reg[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable data memory for the RV64 MEM stage.
// Handles SB/SH/SW/SD and LB/LH/LW/LD/LBU/LHU/LWU, splits accesses that cross
// an 8-byte boundary into two beats and flags illegal / out-of-range accesses.
//   clk  in   clock
//   rst  in   synchronous active-high reset (memory contents survive)
//   bus  slave side of data_mem_lsu_if (request handshake + response pulse)
module data_mem_lsu
   import dmem_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int DEPTH_WORDS = 512
) (
   input logic           clk,
   input logic           rst,
   data_mem_lsu_if.slave bus
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [64:0] MEM_BYTES = 65'(DEPTH_WORDS) * 65'd8;

   state_t            state_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic              rsp_load_reg;
   logic              rsp_mis_reg;
   logic [2:0]        rsp_funct3_reg;
   logic [2:0]        rsp_off_reg;
   logic [XLEN-1:0]   lo_word_reg;
   logic [AW-1:0]     beat_addr_reg;
   logic              beat_we_reg;
   logic [7:0]        beat_be_reg;
   logic [XLEN-1:0]   beat_wdata_reg;

   lane_t             lane;
   logic [2:0]        req_off;
   logic [AW-1:0]     word_idx;
   logic [3:0]        size_bytes;
   logic [64:0]       last_byte;
   logic              range_err;
   logic              funct_err;
   logic              req_err;
   logic              ready;
   logic              accept;
   logic [2*XLEN-1:0] wdata_shift;

   logic              bank_en;
   logic [7:0]        bank_we;
   logic [AW-1:0]     bank_addr;
   logic [XLEN-1:0]   bank_wdata;
   logic [XLEN-1:0]   bank_rdata;

   logic [2*XLEN-1:0] load_pair;
   logic [XLEN-1:0]   load_shift;
   logic [XLEN-1:0]   load_ext;

   // ---------------- request decode ----------------
   assign req_off    = bus.req_addr[2:0];
   assign word_idx   = bus.req_addr[AW+2:3];
   assign lane       = lane_info(bus.req_funct3, req_off);
   assign size_bytes = 4'd1 << bus.req_funct3[1:0];
   // 65-bit sum so an address near 2^64 cannot wrap back into range.
   assign last_byte  = {1'b0, bus.req_addr} + 65'(size_bytes) - 65'd1;
   assign range_err  = (last_byte >= MEM_BYTES);
   assign funct_err  = bus.req_we ? !(bus.req_funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD})
                                  : (bus.req_funct3 == F3_BAD_LOAD);
   assign req_err    = range_err || funct_err;

   assign ready  = !rst && (state_reg == IDLE);
   assign accept = bus.req_valid && ready;

   // Low half lands in the addressed word, high half is the spill for beat 2.
   assign wdata_shift = {{XLEN{1'b0}}, bus.req_wdata} << {req_off, 3'b000};

   // ---------------- RAM port steering ----------------
   always_comb begin
      bank_en    = 1'b0;
      bank_we    = 8'h00;
      bank_addr  = word_idx;
      bank_wdata = wdata_shift[XLEN-1:0];
      if (state_reg == BEAT2) begin
         // Reset during the second beat abandons the spill write.
         bank_en    = !rst;
         bank_addr  = beat_addr_reg;
         bank_we    = beat_we_reg ? beat_be_reg : 8'h00;
         bank_wdata = beat_wdata_reg;
      end else if (accept && !req_err) begin
         bank_en = 1'b1;
         bank_we = bus.req_we ? lane.be[7:0] : 8'h00;
      end
   end

   dmem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (bank_we),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata)
   );

   // ---------------- FSM and response registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         rsp_valid_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
         rsp_load_reg   <= 1'b0;
         rsp_mis_reg    <= 1'b0;
         rsp_funct3_reg <= 3'b000;
         rsp_off_reg    <= 3'b000;
         lo_word_reg    <= '0;
         beat_addr_reg  <= '0;
         beat_we_reg    <= 1'b0;
         beat_be_reg    <= 8'h00;
         beat_wdata_reg <= '0;
      end else begin
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  rsp_err_reg    <= req_err;
                  rsp_load_reg   <= !bus.req_we && !req_err;
                  rsp_mis_reg    <= lane.misaligned && !req_err;
                  rsp_funct3_reg <= bus.req_funct3;
                  rsp_off_reg    <= req_off;
                  beat_addr_reg  <= word_idx + AW'(1);
                  beat_we_reg    <= bus.req_we;
                  beat_be_reg    <= lane.be[15:8];
                  beat_wdata_reg <= wdata_shift[2*XLEN-1:XLEN];
                  if (lane.misaligned && !req_err) begin
                     state_reg <= BEAT2;
                  end else begin
                     rsp_valid_reg <= 1'b1;
                  end
               end
            end
            BEAT2: begin
               // Bank output still holds the low word; keep it before the
               // second read replaces it.
               lo_word_reg   <= bank_rdata;
               rsp_valid_reg <= 1'b1;
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // ---------------- load alignment and extension ----------------
   assign load_pair  = rsp_mis_reg ? {bank_rdata, lo_word_reg} : {{XLEN{1'b0}}, bank_rdata};
   assign load_shift = XLEN'(load_pair >> {rsp_off_reg, 3'b000});

   always_comb begin
      load_ext = '0;
      case (rsp_funct3_reg)
         F3_LB:   load_ext = {{56{load_shift[7]}},  load_shift[7:0]};
         F3_LH:   load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
         F3_LW:   load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
         F3_LD:   load_ext = load_shift;
         F3_LBU:  load_ext = {56'd0, load_shift[7:0]};
         F3_LHU:  load_ext = {48'd0, load_shift[15:0]};
         F3_LWU:  load_ext = {32'd0, load_shift[31:0]};
         default: load_ext = '0;
      endcase
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_err   = rsp_valid_reg && rsp_err_reg;
   assign bus.rsp_rdata = (rsp_valid_reg && rsp_load_reg) ? load_ext : '0;

endmodule
